// File: rtl/hazard_ctrl_fsm.sv
// hazard_ctrl_fsm
// Sequential hazard controller for the 5-stage MIPS pipeline. It detects
// load-use and store-after-load hazards on the instruction in IF/ID and
// sequences stall and jump-flush windows with a small FSM and down-counter.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds the StallCycles and
// FlushEvents performance counters (saturating, cleared by reset).
//
// Ports:
//   Clk                in  pipeline clock, rising edge
//   Rst                in  asynchronous reset, active-low
//   IF_ID_Instruction  in  instruction currently in ID
//   ID_EX_RTreg        in  destination (rt) of the instruction in EX
//   ID_EX_MemRead      in  instruction in EX is a load
//   EX_MEM_MemRead     in  instruction in MEM is a load
//   JumpID             in  jump decoded and resolved in ID this cycle
//   BranchTaken        in  branch resolved taken this cycle
//   PCWrite            out PC update enable
//   IF_ID_Write        out IF/ID register enable
//   IF_ID_Flush        out zero IF/ID on next edge
//   ID_EX_Flush        out zero ID/EX control on next edge (bubble)
//   StallCycles        out (HAZARD_PERF_CNT_EN) cycles with StallActive=1
//   FlushEvents        out (HAZARD_PERF_CNT_EN) cycles with any flush
//   StallActive        out high whenever PCWrite=0
module hazard_ctrl_fsm #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned JUMP_BUBBLES      = 1,
  parameter logic [5:0]  SW_OPCODE         = 6'b101011
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           IF_ID_Instruction,
  input  logic [REG_ADDR_W-1:0] ID_EX_RTreg,
  input  logic                  ID_EX_MemRead,
  input  logic                  EX_MEM_MemRead,
  input  logic                  JumpID,
  input  logic                  BranchTaken,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushEvents,
`endif
  output logic                  StallActive
);

  localparam int unsigned CNT_MAX = (LOAD_STALL_CYCLES > JUMP_BUBBLES) ?
                                    LOAD_STALL_CYCLES : JUMP_BUBBLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] JUMP_INIT = CNT_W'(JUMP_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_STALL,
    JUMP_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] id_rs, id_rt;
  logic                  lu, sl, hazard;

  assign id_rs = REG_ADDR_W'(IF_ID_Instruction[25:21]);
  assign id_rt = REG_ADDR_W'(IF_ID_Instruction[20:16]);

  assign lu = ID_EX_MemRead && (ID_EX_RTreg != '0) &&
              ((id_rs == ID_EX_RTreg) || (id_rt == ID_EX_RTreg));
  assign sl = (IF_ID_Instruction[31:26] == SW_OPCODE) &&
              (ID_EX_MemRead || EX_MEM_MemRead);
  assign hazard = lu || sl;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The first stall/flush cycle is served from IDLE, so the
  // counter is loaded with (length - 1) and the window ends at counter == 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!BranchTaken) begin
          if (hazard) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_INIT;
            end
          end else if (JumpID) begin
            if (JUMP_BUBBLES > 1) begin
              state_d = JUMP_FLUSH;
              cnt_d   = JUMP_INIT;
            end
          end
        end
      end
      LOAD_STALL, JUMP_FLUSH: begin
        if (BranchTaken || (cnt_q == CNT_ONE)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Mealy outputs; reset forces the pass-through defaults immediately.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (Rst) begin
      if (BranchTaken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (hazard) begin
              PCWrite     = 1'b0;
              IF_ID_Write = 1'b0;
              ID_EX_Flush = 1'b1;
            end else if (JumpID) begin
              IF_ID_Flush = 1'b1;
            end
          end
          LOAD_STALL: begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
          JUMP_FLUSH: begin
            IF_ID_Flush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign StallActive = !PCWrite;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (StallActive && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if ((IF_ID_Flush || ID_EX_Flush) && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushEvents = flush_events_q;
`endif

endmodule

// File: doc/hazard_ctrl_fsm.md
Name: hazard_ctrl_fsm

Overview:
Sequential hazard controller for the 5-stage MIPS pipeline. It detects load-use and store-after-load hazards on the instruction in IF/ID and owns PCWrite, IF_ID_Write and the IF/ID and ID/EX flushes. Stall length and jump bubble count are parametrised and sequenced by an internal FSM with a down-counter, replacing purely combinational stall generation. It sits between the IF/ID register, the ID/EX control fields and the PC/branch mux.

Parameters:
REG_ADDR_W, 5, register specifier width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1; covers multi-cycle data memory)
JUMP_BUBBLES, 1, IF/ID flush cycles after a jump resolves in ID (>=1)
SW_OPCODE, 6'b101011, opcode treated as store for the store-after-load check

Ports:
Clk  in  1  pipeline clock, rising edge
Rst  in  1  asynchronous reset, active-low
IF_ID_Instruction  in  32  instruction currently in ID
ID_EX_RTreg  in  REG_ADDR_W  destination (rt) of the instruction in EX
ID_EX_MemRead  in  1  instruction in EX is a load
EX_MEM_MemRead  in  1  instruction in MEM is a load
JumpID  in  1  jump decoded and resolved in ID this cycle
BranchTaken  in  1  branch resolved taken this cycle
PCWrite  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  zero IF/ID on next edge
ID_EX_Flush  out  1  zero ID/EX control on next edge (bubble)
StallActive  out  1  high in any cycle where PCWrite=0

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, counter=0. While in reset: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, StallActive=0. Reset mid-stall aborts the stall immediately.
- Outputs are Mealy: a function of current state and the present inputs. State and counter update on the rising Clk edge.
- Hazard term LU = ID_EX_MemRead && ID_EX_RTreg!=0 && (Instr[25:21]==ID_EX_RTreg || Instr[20:16]==ID_EX_RTreg).
- Store term SL = Instr[31:26]==SW_OPCODE && (ID_EX_MemRead || EX_MEM_MemRead).
- States: IDLE, LOAD_STALL, JUMP_FLUSH. Counter width is clog2(max(LOAD_STALL_CYCLES, JUMP_BUBBLES)+1).
- Defaults in every state: PCWrite=1, IF_ID_Write=1, both flushes=0.
- Priority in IDLE: BranchTaken > (LU or SL) > JumpID.
- IDLE with BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1. Stay in IDLE.
- IDLE with LU or SL: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
  - If LOAD_STALL_CYCLES>1: go to LOAD_STALL with counter=LOAD_STALL_CYCLES-1.
  - Otherwise stay in IDLE.
- IDLE with JumpID: IF_ID_Flush=1.
  - If JUMP_BUBBLES>1: go to JUMP_FLUSH with counter=JUMP_BUBBLES-1.
  - Otherwise stay in IDLE.
- LOAD_STALL: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Counter decrements each cycle; at counter==1 go to IDLE. Hazard inputs are ignored in this state (no re-trigger, no extension).
- JUMP_FLUSH: IF_ID_Flush=1, PCWrite=1. Counter decrements; at counter==1 go to IDLE.
- BranchTaken in LOAD_STALL or JUMP_FLUSH: both flushes=1, PCWrite=1, IF_ID_Write=1, next state IDLE, counter cleared. The branch wins over any pending stall.
- A JumpID that coincides with LU/SL is not acted on. The stall is served first; the jump is re-evaluated when IDLE resumes with the instruction still held in IF/ID.
- StallActive = !PCWrite.
- Total stall length for one load-use hazard is exactly LOAD_STALL_CYCLES cycles.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs StallCycles[31:0] and FlushEvents[31:0].
  - StallCycles increments on every cycle with StallActive=1.
  - FlushEvents increments on every cycle with IF_ID_Flush=1 or ID_EX_Flush=1 (+1 per cycle, not per flush).
  - Both saturate at 32'hFFFFFFFF and clear on Rst=0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- LOAD_STALL_CYCLES=1, "lw $3,4($3)" in EX (ID_EX_RTreg=3, ID_EX_MemRead=1), "add $1,$2,$3" in ID -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle defaults, state IDLE.
- LOAD_STALL_CYCLES=3, same hazard -> exactly 3 consecutive stall cycles, then defaults; StallActive high for 3 cycles. ID_EX_RTreg=0 with a matching rs -> no stall.
- JUMP_BUBBLES=2, JumpID=1 for one cycle -> IF_ID_Flush=1 for 2 cycles, PCWrite=1 throughout.
- LOAD_STALL_CYCLES=3: BranchTaken=1 in the 2nd stall cycle -> both flushes=1, PCWrite=1 that cycle, next cycle IDLE defaults.
- Simultaneous JumpID and LU -> stall only (IF_ID_Flush=0); after the stall, IF_ID_Flush=1 for the held jump. Rst=0 mid-JUMP_FLUSH -> outputs return to defaults immediately.
- HAZARD_PERF_CNT_EN: 2 load-use hazards (LOAD_STALL_CYCLES=2) plus 1 taken branch -> StallCycles=4, FlushEvents=5.
